// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between the 6502 core
// (port A) and the loader/DMA path (port B). One access per cycle goes to the
// RAM. Grants are combinational. Read data is steered back to the port that
// issued the read, one cycle after the grant.
module ram_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 8,
  parameter int ARB_MODE     = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  // port A (6502 core)
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  // port B (loader / DMA)
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  // RAM side
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic          ram_re,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic {
    WIN_A = 1'b0,
    WIN_B = 1'b1
  } win_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  win_t       last_win;
  logic [7:0] starve_cnt;
  logic       pend_a_p1;
  logic       pend_b_p1;
  logic       a_tie;
  logic       a_win;
  logic       b_win;

  // Saturating increment keeps the starvation counter from wrapping to zero.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Who wins when both ports request in the same cycle.
  function automatic logic a_wins_tie(input win_t lw, input logic [7:0] cnt);
    if (ARB_MODE == 0) return (lw == WIN_B);
    else               return (cnt < LIMIT);
  endfunction

  // Grant decision; ungated by reset so the flops never see rst_n as data.
  always_comb begin
    a_tie = a_wins_tie(last_win, starve_cnt);
    a_win = a_req & (~b_req | a_tie);
    b_win = b_req & (~a_req | ~a_tie);
  end

  // Outputs: grants and RAM strobes are forced low while reset is held.
  always_comb begin
    a_gnt    = a_win & rst_n;
    b_gnt    = b_win & rst_n;
    ram_addr = b_gnt ? b_addr  : a_addr;
    ram_din  = b_gnt ? b_wdata : a_wdata;
    ram_we   = (a_gnt & a_we)  | (b_gnt & b_we);
    ram_re   = (a_gnt & ~a_we) | (b_gnt & ~b_we);
  end

  // ---- stage p1: read return, valid one cycle after the grant ----
  // Pending-read flags mark which port owns the RAM output next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_a_p1 <= 1'b0;
      pend_b_p1 <= 1'b0;
    end else begin
      pend_a_p1 <= a_win & ~a_we;
      pend_b_p1 <= b_win & ~b_we;
    end
  end

  // Round-robin history: remembers the port granted most recently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_win <= WIN_B;
    end else if (a_win) begin
      last_win <= WIN_A;
    end else if (b_win) begin
      last_win <= WIN_B;
    end
  end

  // Starvation counter: consecutive cycles B has asked and been refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 8'd0;
    end else if (b_req & ~b_win) begin
      starve_cnt <= sat_inc(starve_cnt);
    end else begin
      starve_cnt <= 8'd0;
    end
  end

  // Read data is zero whenever the port has no valid response.
  always_comb begin
    a_rvalid = pend_a_p1;
    b_rvalid = pend_b_p1;
    a_rdata  = pend_a_p1 ? ram_dout : '0;
    b_rdata  = pend_b_p1 ? ram_dout : '0;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: two instances (round-robin and fixed priority)
// share the same stimulus, each with its own behavioural RAM. The driver
// pushes per-cycle expectations and expected read data into queues; a
// monitor on the falling edge pops and compares.
module tb_ram_arbiter;

  localparam logic [1:0] GA = 2'b10;
  localparam logic [1:0] GB = 2'b01;
  localparam logic [1:0] GN = 2'b00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata;

  logic        rr_a_gnt, rr_a_rvalid, rr_b_gnt, rr_b_rvalid, rr_we, rr_re;
  logic [7:0]  rr_a_rdata, rr_b_rdata, rr_din;
  logic [15:0] rr_addr;
  bit   [7:0]  rr_dout;
  logic        fp_a_gnt, fp_a_rvalid, fp_b_gnt, fp_b_rvalid, fp_we, fp_re;
  logic [7:0]  fp_a_rdata, fp_b_rdata, fp_din;
  logic [15:0] fp_addr;
  bit   [7:0]  fp_dout;

  bit   [7:0]  mem_rr [0:65535];
  bit   [7:0]  mem_fp [0:65535];

  typedef struct packed {
    logic        ag, bg, arv, brv, rwe, rre;
    logic [15:0] addr;
    logic [7:0]  din;
  } exp_t;

  exp_t       eq_rr[$], eq_fp[$];
  logic [7:0] qa_rr[$], qb_rr[$], qa_fp[$], qb_fp[$];
  logic       prv_rr_a, prv_rr_b, prv_fp_a, prv_fp_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(16), .DW(8), .ARB_MODE(0), .STARVE_LIMIT(4)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(rr_a_gnt), .a_rvalid(rr_a_rvalid), .a_rdata(rr_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(rr_b_gnt), .b_rvalid(rr_b_rvalid), .b_rdata(rr_b_rdata),
    .ram_addr(rr_addr), .ram_we(rr_we), .ram_re(rr_re), .ram_din(rr_din),
    .ram_dout(rr_dout)
  );

  ram_arbiter #(.AW(16), .DW(8), .ARB_MODE(1), .STARVE_LIMIT(4)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(fp_a_gnt), .a_rvalid(fp_a_rvalid), .a_rdata(fp_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(fp_b_gnt), .b_rvalid(fp_b_rvalid), .b_rdata(fp_b_rdata),
    .ram_addr(fp_addr), .ram_we(fp_we), .ram_re(fp_re), .ram_din(fp_din),
    .ram_dout(fp_dout)
  );

  // Behavioural single-port RAMs with registered read output.
  always @(posedge clk) begin
    if (rr_we) mem_rr[rr_addr] <= rr_din;
    if (rr_re) rr_dout <= mem_rr[rr_addr];
    if (fp_we) mem_fp[fp_addr] <= fp_din;
    if (fp_re) fp_dout <= mem_fp[fp_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] g, input logic parv, input logic pbrv);
    exp_t e;
    e.ag   = g[1];
    e.bg   = g[0];
    e.arv  = parv;
    e.brv  = pbrv;
    e.rwe  = (g[1] & a_we) | (g[0] & b_we);
    e.rre  = (g[1] & ~a_we) | (g[0] & ~b_we);
    e.addr = g[0] ? b_addr : a_addr;
    e.din  = g[0] ? b_wdata : a_wdata;
    return e;
  endfunction

  // Drive one cycle of stimulus and queue the expected response for both DUTs.
  task automatic step(input logic ar, input logic aw, input logic [15:0] aa, input logic [7:0] ad,
                      input logic br, input logic bw, input logic [15:0] ba, input logic [7:0] bd,
                      input logic [1:0] g_rr, input logic [1:0] g_fp,
                      input logic [7:0] xa, input logic [7:0] xb);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    eq_rr.push_back(mk(g_rr, prv_rr_a, prv_rr_b));
    eq_fp.push_back(mk(g_fp, prv_fp_a, prv_fp_b));
    if (g_rr[1] && !aw) qa_rr.push_back(xa);
    if (g_rr[0] && !bw) qb_rr.push_back(xb);
    if (g_fp[1] && !aw) qa_fp.push_back(xa);
    if (g_fp[0] && !bw) qb_fp.push_back(xb);
    prv_rr_a = g_rr[1] & ~aw;
    prv_rr_b = g_rr[0] & ~bw;
    prv_fp_a = g_fp[1] & ~aw;
    prv_fp_b = g_fp[0] & ~bw;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, GN, GN, 8'h00, 8'h00);
  endtask

  // Assert reset mid-cycle with the current requests left in place.
  task automatic do_reset(input int n);
    exp_t z;
    z = '0;
    z.addr = a_addr;
    z.din  = a_wdata;
    rst_n = 1'b0;
    qa_rr.delete(); qb_rr.delete(); qa_fp.delete(); qb_fp.delete();
    prv_rr_a = 1'b0; prv_rr_b = 1'b0; prv_fp_a = 1'b0; prv_fp_b = 1'b0;
    for (int i = 0; i < n; i++) begin
      eq_rr.push_back(z);
      eq_fp.push_back(z);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  // Both ports read continuously; bit i of a pattern is 1 when A wins cycle i.
  task automatic burst(input int n, input logic [15:0] prr, input logic [15:0] pfp);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 16'h0010, 8'h00, 1'b1, 1'b0, 16'h0020, 8'h00,
           prr[i] ? GA : GB, pfp[i] ? GA : GB, 8'h11, 8'h22);
    end
  endtask

  task automatic chk_dut(input string t, input exp_t e,
                         input logic ag, input logic bg, input logic arv, input logic brv,
                         input logic we, input logic re, input logic [15:0] addr, input logic [7:0] din,
                         input logic [7:0] ard, input logic [7:0] brd,
                         input logic ha, input logic [7:0] xa, input logic hb, input logic [7:0] xb);
    chk({t, "_a_gnt"}, 32'(ag), 32'(e.ag));
    chk({t, "_b_gnt"}, 32'(bg), 32'(e.bg));
    chk({t, "_ram_we"}, 32'(we), 32'(e.rwe));
    chk({t, "_ram_re"}, 32'(re), 32'(e.rre));
    if (e.ag | e.bg) chk({t, "_ram_addr"}, 32'(addr), 32'(e.addr));
    if (e.rwe) chk({t, "_ram_din"}, 32'(din), 32'(e.din));
    chk({t, "_a_rvalid"}, 32'(arv), 32'(e.arv));
    chk({t, "_b_rvalid"}, 32'(brv), 32'(e.brv));
    if (arv) begin
      if (!ha) chk({t, "_a_rdata_unexpected"}, 32'd1, 32'd0);
      else     chk({t, "_a_rdata"}, 32'(ard), 32'(xa));
    end else begin
      chk({t, "_a_rdata_idle"}, 32'(ard), 32'd0);
    end
    if (brv) begin
      if (!hb) chk({t, "_b_rdata_unexpected"}, 32'd1, 32'd0);
      else     chk({t, "_b_rdata"}, 32'(brd), 32'(xb));
    end else begin
      chk({t, "_b_rdata_idle"}, 32'(brd), 32'd0);
    end
    chk({t, "_gnt_exclusive"}, 32'(ag & bg), 32'd0);
    chk({t, "_gnt_without_req"}, 32'((ag & ~a_req) | (bg & ~b_req)), 32'd0);
    chk({t, "_we_and_re"}, 32'(we & re), 32'd0);
  endtask

  // Monitor: pops the expectation for this cycle and any returned read data.
  logic       m_ha, m_hb;
  logic [7:0] m_xa, m_xb;
  exp_t       m_e;
  always @(negedge clk) begin
    if (eq_rr.size() == 0 || eq_fp.size() == 0) begin
      chk("expectation_underrun", 32'd1, 32'd0);
    end else begin
      m_e  = eq_rr.pop_front();
      m_ha = rr_a_rvalid && (qa_rr.size() != 0);
      m_xa = m_ha ? qa_rr.pop_front() : 8'h00;
      m_hb = rr_b_rvalid && (qb_rr.size() != 0);
      m_xb = m_hb ? qb_rr.pop_front() : 8'h00;
      chk_dut("rr", m_e, rr_a_gnt, rr_b_gnt, rr_a_rvalid, rr_b_rvalid, rr_we, rr_re,
              rr_addr, rr_din, rr_a_rdata, rr_b_rdata, m_ha, m_xa, m_hb, m_xb);
      m_e  = eq_fp.pop_front();
      m_ha = fp_a_rvalid && (qa_fp.size() != 0);
      m_xa = m_ha ? qa_fp.pop_front() : 8'h00;
      m_hb = fp_b_rvalid && (qb_fp.size() != 0);
      m_xb = m_hb ? qb_fp.pop_front() : 8'h00;
      chk_dut("fp", m_e, fp_a_gnt, fp_b_gnt, fp_a_rvalid, fp_b_rvalid, fp_we, fp_re,
              fp_addr, fp_din, fp_a_rdata, fp_b_rdata, m_ha, m_xa, m_hb, m_xb);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h1234; a_wdata = 8'h00;
    b_req = 1'b0; b_we = 1'b0; b_addr = 16'h0000; b_wdata = 8'h00;
    prv_rr_a = 1'b0; prv_rr_b = 1'b0; prv_fp_a = 1'b0; prv_fp_b = 1'b0;
    @(posedge clk);
    #1;
    // power-on reset with a read request already pending
    do_reset(3);

    // single port A: write 0x5A to 0x1234 then read it back
    step(1'b1, 1'b1, 16'h1234, 8'h5A, 1'b0, 1'b0, 16'h0000, 8'h00, GA, GA, 8'h00, 8'h00);
    step(1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, GA, GA, 8'h5A, 8'h00);
    idle();

    // reset asserted while A's read is in flight: response is dropped
    step(1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, GA, GA, 8'h5A, 8'h00);
    do_reset(2);
    idle();
    idle();

    // seed data for the contention tests
    step(1'b1, 1'b1, 16'h0010, 8'h11, 1'b0, 1'b0, 16'h0000, 8'h00, GA, GA, 8'h00, 8'h00);
    step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0020, 8'h22, GB, GB, 8'h00, 8'h00);
    // lone B read is granted with zero wait
    step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0020, 8'h00, GB, GB, 8'h00, 8'h22);

    // 6 contested cycles: rr A,B,A,B,A,B ; fp A,A,A,A,B,A
    burst(6, 16'b010101, 16'b101111);
    idle();
    // 10 contested cycles: rr alternates ; fp A x4 then B, repeated
    burst(10, 16'b0101010101, 16'b0111101111);
    idle();
    idle();

    // B writes 0xC3 to 0xFFFF, A reads it on the very next cycle
    step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 16'hFFFF, 8'hC3, GB, GB, 8'h00, 8'h00);
    step(1'b1, 1'b0, 16'hFFFF, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, GA, GA, 8'hC3, 8'h00);
    idle();
    idle();

    chk("rr_a_queue_drained", 32'(qa_rr.size()), 32'd0);
    chk("rr_b_queue_drained", 32'(qb_rr.size()), 32'd0);
    chk("fp_a_queue_drained", 32'(qa_fp.size()), 32'd0);
    chk("fp_b_queue_drained", 32'(qb_fp.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
